// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared types, defaults and channel-order helpers for the pulse sequencer
package pulse_seq_pkg;

   localparam int CH_NUM_DEF = 6;
   localparam int CNT_W_DEF  = 16;
   localparam int REP_W_DEF  = 8;
   localparam int IDX_W      = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   function automatic logic [IDX_W-1:0] first_ch(input logic dir);
      return dir ? IDX_W'(CH_NUM_DEF - 1) : IDX_W'(0);
   endfunction

   function automatic logic [IDX_W-1:0] last_ch(input logic dir);
      return dir ? IDX_W'(0) : IDX_W'(CH_NUM_DEF - 1);
   endfunction

   // Wraps at either end so a sweep boundary looks like any other step.
   function automatic logic [IDX_W-1:0] next_ch(input logic [IDX_W-1:0] ch, input logic dir);
      if (dir)
         return (ch == IDX_W'(0)) ? IDX_W'(CH_NUM_DEF - 1) : ch - IDX_W'(1);
      else
         return (ch == IDX_W'(CH_NUM_DEF - 1)) ? IDX_W'(0) : ch + IDX_W'(1);
   endfunction

endpackage

// File: rtl/pulse_seq_timer.sv
// rtl/pulse_seq_timer.sv - loadable down counter with registered last-cycle flag
module pulse_seq_timer
   import pulse_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;

   always_comb begin
      count_nxt = count;
      if (load)
         count_nxt = load_val;
      else if (count != '0)
         count_nxt = count - CNT_W'(1);
   end

   // expired is high during the final cycle of the loaded interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         expired <= 1'b0;
      end else begin
         count   <= count_nxt;
         expired <= (count_nxt == CNT_W'(1));
      end
   end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// rtl/pulse_seq_ctrl.sv - start/stop scheduler for one-hot sequential channel pulses
module pulse_seq_ctrl
   import pulse_seq_pkg::*;
#(
   parameter int CH_NUM = CH_NUM_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int REP_W  = REP_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              dir,
   input  logic              mode_cont,
   input  logic [CNT_W-1:0]  dwell,
   input  logic [CNT_W-1:0]  gap,
   input  logic [REP_W-1:0]  repeat_n,
   output logic [CH_NUM-1:0] pulse_out,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  step_idx
);

   state_t state;
   state_t state_nxt;

   logic             dir_q;
   logic             cont_q;
   logic [CNT_W-1:0] dwell_q;
   logic [CNT_W-1:0] gap_q;
   logic [REP_W-1:0] sweeps_q;
   logic [IDX_W-1:0] ch_q;
   logic             fin_q;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_exp;

   logic [CNT_W-1:0] dwell_in_eff;
   logic [REP_W-1:0] rep_in_eff;
   logic             launch;
   logic             last_step;
   logic             step_end;

   logic [CH_NUM-1:0] pulse_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic [IDX_W-1:0]  step_nxt;

   assign dwell_in_eff = (dwell == '0) ? CNT_W'(1) : dwell;
   assign rep_in_eff   = (repeat_n == '0) ? REP_W'(1) : repeat_n;
   assign launch       = (state == IDLE) && start && !stop;
   assign last_step    = !cont_q && (sweeps_q == REP_W'(1)) && (ch_q == last_ch(dir_q));
   assign step_end     = (state == PULSE) && tmr_exp && !stop;

   pulse_seq_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // The timer reloads on every PULSE/GAP entry, including PULSE->PULSE.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = dwell_q;
      case (state)
         IDLE: begin
            if (launch) begin
               state_nxt = PULSE;
               tmr_load  = 1'b1;
               tmr_val   = dwell_in_eff;
            end
         end
         PULSE: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (tmr_exp) begin
               if (last_step) begin
                  state_nxt = IDLE;
               end else if (gap_q != '0) begin
                  state_nxt = GAP;
                  tmr_load  = 1'b1;
                  tmr_val   = gap_q;
               end else begin
                  state_nxt = PULSE;
                  tmr_load  = 1'b1;
               end
            end
         end
         GAP: begin
            if (stop) begin
               state_nxt = IDLE;
            end else if (tmr_exp) begin
               state_nxt = PULSE;
               tmr_load  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q    <= 1'b0;
         cont_q   <= 1'b0;
         dwell_q  <= CNT_W'(1);
         gap_q    <= '0;
         sweeps_q <= REP_W'(1);
         ch_q     <= '0;
         fin_q    <= 1'b0;
      end else begin
         fin_q <= step_end && last_step;
         if (launch) begin
            dir_q    <= dir;
            cont_q   <= mode_cont;
            dwell_q  <= dwell_in_eff;
            gap_q    <= gap;
            sweeps_q <= rep_in_eff;
            ch_q     <= first_ch(dir);
         end else if (step_end && !last_step) begin
            ch_q <= next_ch(ch_q, dir_q);
            if (!cont_q && (ch_q == last_ch(dir_q)))
               sweeps_q <= sweeps_q - REP_W'(1);
         end
      end
   end

   always_comb begin
      pulse_nxt = '0;
      busy_nxt  = (state != IDLE);
      done_nxt  = fin_q;
      step_nxt  = step_idx;
      if (state == PULSE) begin
         pulse_nxt[ch_q] = 1'b1;
         step_nxt        = ch_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         step_idx  <= '0;
      end else begin
         pulse_out <= pulse_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         step_idx  <= step_nxt;
      end
   end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// tb/tb_pulse_seq_ctrl.sv - scoreboard bench for pulse_seq_ctrl against a per-cycle trace model
module tb_pulse_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        dir = 1'b0;
   logic        mode_cont = 1'b0;
   logic [15:0] dwell = 16'd1;
   logic [15:0] gap = 16'd0;
   logic [7:0]  repeat_n = 8'd1;
   logic [5:0]  pulse_out;
   logic        busy;
   logic        done;
   logic [2:0]  step_idx;

   typedef struct {
      int         cyc;
      logic [5:0] p;
      logic       b;
      logic       d;
      logic [2:0] s;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   pulse_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .dir       (dir),
      .mode_cont (mode_cont),
      .dwell     (dwell),
      .gap       (gap),
      .repeat_n  (repeat_n),
      .pulse_out (pulse_out),
      .busy      (busy),
      .done      (done),
      .step_idx  (step_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int got, input int expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, got, expv);
      end
   endtask

   // Monitor: outputs packed as {pulse_out, busy, done, step_idx}.
   always @(negedge clk) begin
      if (rst_n) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check("missed_output", 0, e.cyc);
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("trace", int'({pulse_out, busy, done, step_idx}), int'({e.p, e.b, e.d, e.s}));
         end else if (pulse_out != 6'd0 || busy || done) begin
            check("unexpected_activity", int'({pulse_out, busy, done, step_idx}), int'({6'd0, 1'b0, 1'b0, step_idx}));
         end
      end
   end

   // Reference: a run is a list of channel visits, each D cycles high followed by G low cycles.
   task automatic push_run(input int n, input bit d, input int dw, input int gp, input int rp, input bit cont);
      int dd;
      int rr;
      int t;
      int ch;
      dd = (dw == 0) ? 1 : dw;
      rr = (rp == 0) ? 1 : rp;
      t  = n + 1;
      ch = 0;
      for (int r = 0; r < rr; r++) begin
         for (int i = 0; i < 6; i++) begin
            ch = d ? 5 - i : i;
            for (int k = 0; k < dd; k++) begin
               sb.push_back('{t, 6'(1 << ch), 1'b1, 1'b0, 3'(ch)});
               t++;
            end
            if (cont || !(r == rr - 1 && i == 5)) begin
               for (int k = 0; k < gp; k++) begin
                  sb.push_back('{t, 6'd0, 1'b1, 1'b0, 3'(ch)});
                  t++;
               end
            end
         end
      end
      if (!cont)
         sb.push_back('{t, 6'd0, 1'b0, 1'b1, 3'(ch)});
   endtask

   task automatic set_cfg(input bit d, input int dw, input int gp, input int rp, input bit cont);
      dir       = d;
      dwell     = 16'(dw);
      gap       = 16'(gp);
      repeat_n  = 8'(rp);
      mode_cont = cont;
   endtask

   task automatic do_start(output int n);
      start = 1'b1;
      n = cyc + 1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while ((sb.size() != 0 || busy) && i < budget) begin
         @(posedge clk);
         #1;
         i++;
      end
      check("drain_queue_empty", sb.size(), 0);
      check("drain_busy_low", int'(busy), 0);
   endtask

   task automatic run_oneshot(input bit d, input int dw, input int gp, input int rp, input bit disturb);
      int n0;
      int dd;
      int rr;
      int tlen;
      dd = (dw == 0) ? 1 : dw;
      rr = (rp == 0) ? 1 : rp;
      tlen = rr * (6 * dd + 5 * gp) + (rr - 1) * gp;
      set_cfg(d, dw, gp, rp, 1'b0);
      push_run(cyc + 1, d, dw, gp, rp, 1'b0);
      do_start(n0);
      if (disturb) begin
         wait_cyc(n0 + $urandom_range(0, tlen - 2));
         dwell     = 16'($urandom_range(0, 9));
         gap       = 16'($urandom_range(0, 9));
         dir       = ~dir;
         mode_cont = 1'b1;
         start     = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      wait_idle(tlen + 20);
   endtask

   initial begin
      int n0;
      int s_at;

      repeat (3) @(posedge clk);
      #1;
      check("reset_pulse_out", int'(pulse_out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_step_idx", int'(step_idx), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run_oneshot(1'b0, 3, 2, 1, 1'b0);
      run_oneshot(1'b1, 0, 0, 2, 1'b0);

      // Continuous: 3 full sweeps, then stop during the first dwell cycle of ch3 on sweep 4.
      set_cfg(1'b0, 2, 1, 1, 1'b1);
      push_run(cyc + 1, 1'b0, 2, 1, 5, 1'b1);
      do_start(n0);
      s_at = n0 + 1 + 3 * 18 + 3 * 3;
      wait_cyc(s_at - 1);
      stop = 1'b1;
      while (sb.size() > 0 && sb[$].cyc > s_at)
         void'(sb.pop_back());
      @(posedge clk);
      #1;
      stop = 1'b0;
      @(negedge clk);
      check("stop_last_dwell_ch3", int'(pulse_out), 8);
      @(negedge clk);
      check("stop_pulse_low", int'(pulse_out), 0);
      check("stop_busy_low", int'(busy), 0);
      check("stop_no_done", int'(done), 0);
      wait_idle(10);

      // start and stop together in IDLE: stop wins.
      set_cfg(1'b0, 2, 0, 1, 1'b0);
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("start_stop_idle_busy", int'(busy), 0);
      check("start_stop_idle_pulse", int'(pulse_out), 0);

      // Asynchronous reset in the middle of the ch2 dwell.
      set_cfg(1'b0, 10, 0, 1, 1'b0);
      push_run(cyc + 1, 1'b0, 10, 0, 1, 1'b0);
      do_start(n0);
      wait_cyc(n0 + 24);
      check("pre_reset_ch2", int'(pulse_out), 4);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_pulse", int'(pulse_out), 0);
      check("async_reset_busy", int'(busy), 0);
      check("async_reset_step", int'(step_idx), 0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("post_reset_busy", int'(busy), 0);
      check("post_reset_done", int'(done), 0);

      run_oneshot(1'b0, 2, 1, 2, 1'b1);
      run_oneshot(1'b1, 3, 2, 1, 1'b1);

      for (int i = 0; i < 16; i++)
         run_oneshot(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
